ctrl_reg_initiator: RTL

AXI-Lite master that turns a simple command/response stream into single-beat AXI-Lite read and write transactions. It drives the control-register slave, e.g. to write a wake-up mask or poll the EOC register.
It is used by the boot/debug sequencer and by host-side bridges that must access the control registers without a full AXI master.
Only one transaction is outstanding at a time. Responses are buffered until the consumer accepts them.

---
 rtl/ctrl_reg_initiator.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_reg_initiator.sv
// ctrl_reg_initiator: single-outstanding AXI-Lite master driven by a simple
// command/response stream. One command becomes one AXI-Lite read or write;
// the response is held until the consumer takes it.

package ctrl_reg_initiator_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } axi_lite_ax_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } axi_lite_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi_lite_b_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } axi_lite_r_t;

  typedef struct packed {
    axi_lite_ax_t aw;
    logic         aw_valid;
    axi_lite_w_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_lite_ax_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    axi_lite_b_t b;
    logic        b_valid;
    logic        ar_ready;
    axi_lite_r_t r;
    logic        r_valid;
  } axi_lite_resp_t;

endpackage

module ctrl_reg_initiator #(
  parameter int unsigned AddrWidth       = 32,
  parameter int unsigned DataWidth       = 32,
  parameter type         axi_lite_req_t  = ctrl_reg_initiator_pkg::axi_lite_req_t,
  parameter type         axi_lite_resp_t = ctrl_reg_initiator_pkg::axi_lite_resp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_write_i,
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic [DataWidth-1:0]   cmd_wdata_i,
  input  logic [DataWidth/8-1:0] cmd_wstrb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic [1:0]             rsp_resp_o,
  output logic                   rsp_error_o,
  output logic [15:0]            rsp_latency_o,
  output logic                   busy_o,
  output axi_lite_req_t          axi_lite_master_req_o,
  input  axi_lite_resp_t         axi_lite_master_resp_i
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } state_t;

  state_t state, state_next;

  logic [AddrWidth-1:0]   txn_addr;
  logic [DataWidth-1:0]   txn_wdata;
  logic [DataWidth/8-1:0] txn_wstrb;
  logic                   txn_write;
  logic                   aw_done, w_done;
  logic [15:0]            lat_cnt, lat_inc;
  logic [DataWidth-1:0]   rsp_rdata;
  logic [1:0]             rsp_resp;
  logic [15:0]            rsp_latency;

  logic accept, capture, aw_hs, w_hs, counting;

  // The latency counter only runs while a transaction is on the AXI side.
  assign counting = (state == WR_ADDR_DATA) || (state == WR_RESP) ||
                    (state == RD_ADDR) || (state == RD_DATA);
  assign lat_inc  = (lat_cnt == 16'hFFFF) ? lat_cnt : lat_cnt + 16'd1;

  // State register; reset forces IDLE so any in-flight transaction is dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus all handshake outputs; reset overrides everything to idle.
  always_comb begin
    state_next            = state;
    accept                = 1'b0;
    capture               = 1'b0;
    aw_hs                 = 1'b0;
    w_hs                  = 1'b0;
    cmd_ready_o           = 1'b0;
    rsp_valid_o           = 1'b0;
    axi_lite_master_req_o = '0;
    case (state)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          accept     = 1'b1;
          state_next = cmd_write_i ? WR_ADDR_DATA : RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        axi_lite_master_req_o.aw.addr  = txn_addr;
        axi_lite_master_req_o.w.data   = txn_wdata;
        axi_lite_master_req_o.w.strb   = txn_wstrb;
        axi_lite_master_req_o.aw_valid = !aw_done;
        axi_lite_master_req_o.w_valid  = !w_done;
        aw_hs = !aw_done && axi_lite_master_resp_i.aw_ready;
        w_hs  = !w_done && axi_lite_master_resp_i.w_ready;
        if ((aw_done || aw_hs) && (w_done || w_hs)) begin
          state_next = WR_RESP;
        end
      end
      WR_RESP: begin
        axi_lite_master_req_o.b_ready = 1'b1;
        if (axi_lite_master_resp_i.b_valid) begin
          capture    = 1'b1;
          state_next = RSP;
        end
      end
      RD_ADDR: begin
        axi_lite_master_req_o.ar.addr  = txn_addr;
        axi_lite_master_req_o.ar_valid = 1'b1;
        if (axi_lite_master_resp_i.ar_ready) begin
          state_next = RD_DATA;
        end
      end
      RD_DATA: begin
        axi_lite_master_req_o.r_ready = 1'b1;
        if (axi_lite_master_resp_i.r_valid) begin
          capture    = 1'b1;
          state_next = RSP;
        end
      end
      RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (rst_i) begin
      state_next            = IDLE;
      accept                = 1'b0;
      capture               = 1'b0;
      aw_hs                 = 1'b0;
      w_hs                  = 1'b0;
      cmd_ready_o           = 1'b0;
      rsp_valid_o           = 1'b0;
      axi_lite_master_req_o = '0;
    end
  end

  // Command latch, per-channel done flags, latency count and response capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      txn_addr    <= '0;
      txn_wdata   <= '0;
      txn_wstrb   <= '0;
      txn_write   <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      lat_cnt     <= '0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      rsp_latency <= '0;
    end else begin
      if (accept) begin
        txn_addr  <= cmd_addr_i;
        txn_wdata <= cmd_wdata_i;
        txn_wstrb <= cmd_wstrb_i;
        txn_write <= cmd_write_i;
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
        lat_cnt   <= '0;
      end else if (counting) begin
        lat_cnt <= lat_inc;
      end
      if (aw_hs) begin
        aw_done <= 1'b1;
      end
      if (w_hs) begin
        w_done <= 1'b1;
      end
      if (capture) begin
        rsp_rdata   <= txn_write ? '0 : axi_lite_master_resp_i.r.data;
        rsp_resp    <= txn_write ? axi_lite_master_resp_i.b.resp
                                 : axi_lite_master_resp_i.r.resp;
        rsp_latency <= lat_inc;
      end
    end
  end

  // Response fields read as zero while reset is held.
  assign rsp_rdata_o   = rst_i ? '0 : rsp_rdata;
  assign rsp_resp_o    = rst_i ? 2'b00 : rsp_resp;
  assign rsp_error_o   = rsp_resp_o[1];
  assign rsp_latency_o = rst_i ? 16'd0 : rsp_latency;
  assign busy_o        = !rst_i && (state != IDLE);

endmodule
